// File: rtl/wb_rr_arbiter_n.sv
// Round-robin Wishbone bus arbiter: locks the bus to one master for its whole
// cycle, rotates on release, and optionally forces rotation after HOLD_MAX cycles.
module wb_rr_arbiter_n #(
  parameter int NUM_MASTERS = 4,
  parameter int GNT_W       = 2,
  parameter int HOLD_MAX    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] cyc,
  output logic [GNT_W-1:0]       gnt,
  output logic [NUM_MASTERS-1:0] gnt_onehot,
  output logic                   gnt_valid,
  output logic                   comcyc,
  output logic                   timeout
);

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

  localparam logic [7:0] HOLD_LIM = (HOLD_MAX > 0) ? 8'(HOLD_MAX - 1) : 8'd0;
  localparam logic HOLD_EN = (HOLD_MAX > 0);
  localparam logic [NUM_MASTERS-1:0] ONE = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  state_t                 state_r;
  logic [GNT_W-1:0]       gnt_r;
  logic [GNT_W-1:0]       last_r;
  logic [NUM_MASTERS-1:0] onehot_r;
  logic [7:0]             hold_r;
  logic                   timeout_r;

  logic [NUM_MASTERS-1:0] mask_s;
  logic [GNT_W-1:0]       winner_s;
  logic [GNT_W-1:0]       idx_s;
  logic                   found_s;
  logic                   hold_hit_s;
  logic                   take_s;
  logic                   forced_s;

  // The current owner never competes against itself when a rotation is due.
  assign mask_s     = (state_r == OWNED) ? (cyc & ~onehot_r) : cyc;
  assign hold_hit_s = HOLD_EN && (hold_r == HOLD_LIM);
  assign take_s     = found_s && ((state_r == IDLE) || !cyc[gnt_r] || hold_hit_s);
  assign forced_s   = (state_r == OWNED) && cyc[gnt_r];

  // Rotating priority search starting just after the most recent owner.
  always_comb begin
    found_s  = 1'b0;
    winner_s = last_r;
    idx_s    = last_r;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx_s = GNT_W'((int'(last_r) + k) % NUM_MASTERS);
      if (!found_s && mask_s[idx_s]) begin
        found_s  = 1'b1;
        winner_s = idx_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Ownership state machine with registered grant outputs and hold counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      gnt_r     <= {GNT_W{1'b0}};
      last_r    <= GNT_W'(NUM_MASTERS - 1);
      onehot_r  <= {NUM_MASTERS{1'b0}};
      hold_r    <= 8'd0;
      timeout_r <= 1'b0;
    end else if (take_s) begin
      state_r   <= OWNED;
      gnt_r     <= winner_s;
      last_r    <= winner_s;
      onehot_r  <= ONE << winner_s;
      hold_r    <= 8'd0;
      timeout_r <= forced_s;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        OWNED: begin
          if (!cyc[gnt_r]) begin
            state_r  <= IDLE;
            onehot_r <= {NUM_MASTERS{1'b0}};
            hold_r   <= 8'd0;
          end else if (hold_r != HOLD_LIM) begin
            hold_r <= hold_r + 8'd1;
          end else begin
            hold_r <= hold_r;
          end
        end
        default: begin
          state_r  <= IDLE;
          onehot_r <= {NUM_MASTERS{1'b0}};
        end
      endcase
    end
  end

  assign gnt        = gnt_r;
  assign gnt_onehot = onehot_r;
  assign gnt_valid  = (state_r == OWNED);
  assign timeout    = timeout_r;
  assign comcyc     = (state_r == OWNED) && cyc[gnt_r];

endmodule
